mult_operand_feeder: RTL

// Upstream feeder for the 10-cycle shift-add 8x8 multiplier (in1/in2 -> 16-bit out).

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_op_fifo.sv | 62 ++++++
 rtl/mult_operand_feeder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-add multiplier and its operand feeder.
// The multiplier runs a fixed 10-stage frame; the feeder's RUN counter tracks stages 0..8.
package mult_pkg;

   localparam int OP_W       = 8;
   localparam int RES_W      = 2 * OP_W;
   localparam int CNT_W      = 4;
   localparam int MULT_FRAME = 10;

   // Last stage spent in RUN; the stage after it is the one where the product is final.
   localparam logic [CNT_W-1:0] MULT_LAST_STAGE = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Small operand-pair FIFO: circular buffer with an occupancy counter.
// A push while full is dropped; a push and a pop in the same cycle both take effect.
module mult_op_fifo
   import mult_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 2 * OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W_F = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W_F-1:0] FULL_CNT = CNT_W_F'(DEPTH);

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W_F-1:0] count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mult_operand_feeder.sv
// Feeds queued operand pairs to the 10-cycle shift-add multiplier one at a time,
// sequencing its sync reset and inputs, and returns each product on a valid/ready stream.
module mult_operand_feeder
   import mult_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output logic             mult_rst,
   output logic [OP_W-1:0]  mult_in1,
   output logic [OP_W-1:0]  mult_in2,
   input  logic [RES_W-1:0] mult_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic             busy
);

   feeder_state_t       state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                mult_rst_nxt;
   logic [OP_W-1:0]     mult_in1_nxt, mult_in2_nxt;
   logic                res_valid_nxt;
   logic [RES_W-1:0]    res_data_nxt;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*OP_W-1:0]   fifo_rdata;
   logic                can_start;

   // in_ready ignores a same-cycle pop to keep it free of the FSM decode.
   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign can_start = !fifo_empty && (!res_valid || res_ready);
   assign busy      = (state != IDLE);

   mult_op_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (2 * OP_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({in_a, in_b}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      mult_rst_nxt  = mult_rst;
      mult_in1_nxt  = mult_in1;
      mult_in2_nxt  = mult_in2;
      res_valid_nxt = res_valid;
      res_data_nxt  = res_data;
      fifo_pop      = 1'b0;

      if (res_valid && res_ready)
         res_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            mult_rst_nxt = 1'b1;
            if (can_start) begin
               fifo_pop                     = 1'b1;
               {mult_in1_nxt, mult_in2_nxt} = fifo_rdata;
               mult_rst_nxt                 = 1'b0;
               cnt_nxt                      = '0;
               state_nxt                    = RUN;
            end
         end
         RUN: begin
            mult_rst_nxt = 1'b0;
            if (cnt == MULT_LAST_STAGE)
               state_nxt = DONE;
            else
               cnt_nxt = cnt + 1'b1;
         end
         DONE: begin
            // Multiplier is at its final stage; it wraps to stage 0 on its own.
            res_data_nxt  = mult_out;
            res_valid_nxt = 1'b1;
            mult_rst_nxt  = 1'b1;
            state_nxt     = IDLE;
         end
         default: begin
            mult_rst_nxt = 1'b1;
            state_nxt    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mult_rst  <= 1'b1;
         mult_in1  <= '0;
         mult_in2  <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         mult_rst  <= mult_rst_nxt;
         mult_in1  <= mult_in1_nxt;
         mult_in2  <= mult_in2_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_data_nxt;
      end
   end

endmodule
